// File: rtl/ycrcb_to_rgb_converter.sv
// Full-range BT.601 YCrCb -> RGB converter: 3-stage valid/ready pipeline
// with a single-entry input skid buffer so that datain_ready is a flop.
module ycrcb_to_rgb_converter #(
    parameter int DATAIN_WIDTH  = 32,
    parameter int DATAOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATAIN_WIDTH-1:0]  datain,
    input  logic                     datain_valid,
    output logic                     datain_ready,
    output logic [DATAOUT_WIDTH-1:0] dataout,
    output logic                     dataout_valid,
    input  logic                     dataout_ready
);

    // Q2.14 coefficients, pre-widened to the product width
    localparam logic signed [24:0] KR_C  = 25'sd22970;
    localparam logic signed [24:0] KGB_C = 25'sd5638;
    localparam logic signed [24:0] KGR_C = 25'sd11700;
    localparam logic signed [24:0] KB_C  = 25'sd29032;
    localparam logic signed [26:0] RND_C = 27'sd8192;

    // Drop the 14 fraction bits and clamp to the 8-bit unsigned range.
    function automatic logic [7:0] sat_u8(input logic signed [26:0] sum);
        logic signed [26:0] q;
        logic [7:0]         res;
        q = sum >>> 14;
        if (q < 27'sd0) begin
            res = 8'h00;
        end else if (q > 27'sd255) begin
            res = 8'hFF;
        end else begin
            res = q[7:0];
        end
        return res;
    endfunction

    logic               accept_s;
    logic               en_s;
    logic               skid_full_r;
    logic               skid_full_next_s;
    logic [23:0]        skid_data_r;
    logic [23:0]        src_s;
    logic               datain_unused_s;

    logic               s1_valid_r;
    logic [7:0]         s1_y_r;
    logic signed [8:0]  s1_cr_r;
    logic signed [8:0]  s1_cb_r;
    logic signed [24:0] s1_cr_ext_s;
    logic signed [24:0] s1_cb_ext_s;

    logic               s2_valid_r;
    logic [21:0]        s2_y_r;
    logic signed [24:0] s2_kr_cr_r;
    logic signed [24:0] s2_kgb_cb_r;
    logic signed [24:0] s2_kgr_cr_r;
    logic signed [24:0] s2_kb_cb_r;

    logic signed [26:0] y_ext_s;
    logic signed [26:0] r_sum_s;
    logic signed [26:0] g_sum_s;
    logic signed [26:0] b_sum_s;

    assign accept_s        = datain_valid & datain_ready;
    assign en_s            = ~dataout_valid | dataout_ready;
    assign src_s           = skid_full_r ? skid_data_r : datain[31:8];
    assign datain_unused_s = ^datain[7:0];

    // Skid occupancy: fill when stalled and a pixel arrives, drain on the next advance.
    always_comb begin
        skid_full_next_s = skid_full_r;
        if (en_s && skid_full_r) begin
            skid_full_next_s = 1'b0;
        end else if (accept_s && !en_s) begin
            skid_full_next_s = 1'b1;
        end else begin
            skid_full_next_s = skid_full_r;
        end
    end

    // Skid register and the registered ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_full_r  <= 1'b0;
            skid_data_r  <= 24'd0;
            datain_ready <= 1'b0;
        end else begin
            skid_full_r  <= skid_full_next_s;
            datain_ready <= ~skid_full_next_s;
            if (accept_s && !en_s) begin
                skid_data_r <= datain[31:8];
            end
        end
    end

    // Stage 1: remove the 128 offset from the chroma components.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_y_r     <= 8'd0;
            s1_cr_r    <= 9'sd0;
            s1_cb_r    <= 9'sd0;
        end else if (en_s) begin
            s1_valid_r <= skid_full_r | accept_s;
            s1_y_r     <= src_s[23:16];
            s1_cr_r    <= $signed({1'b0, src_s[15:8]}) - 9'sd128;
            s1_cb_r    <= $signed({1'b0, src_s[7:0]}) - 9'sd128;
        end
    end

    assign s1_cr_ext_s = {{16{s1_cr_r[8]}}, s1_cr_r};
    assign s1_cb_ext_s = {{16{s1_cb_r[8]}}, s1_cb_r};

    // Stage 2: the four chroma products and the scaled luma term.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r  <= 1'b0;
            s2_y_r      <= 22'd0;
            s2_kr_cr_r  <= 25'sd0;
            s2_kgb_cb_r <= 25'sd0;
            s2_kgr_cr_r <= 25'sd0;
            s2_kb_cb_r  <= 25'sd0;
        end else if (en_s) begin
            s2_valid_r  <= s1_valid_r;
            s2_y_r      <= {s1_y_r, 14'd0};
            s2_kr_cr_r  <= KR_C * s1_cr_ext_s;
            s2_kgb_cb_r <= KGB_C * s1_cb_ext_s;
            s2_kgr_cr_r <= KGR_C * s1_cr_ext_s;
            s2_kb_cb_r  <= KB_C * s1_cb_ext_s;
        end
    end

    assign y_ext_s = $signed({5'd0, s2_y_r});
    assign r_sum_s = y_ext_s + {{2{s2_kr_cr_r[24]}}, s2_kr_cr_r} + RND_C;
    assign g_sum_s = y_ext_s - {{2{s2_kgb_cb_r[24]}}, s2_kgb_cb_r}
                             - {{2{s2_kgr_cr_r[24]}}, s2_kgr_cr_r} + RND_C;
    assign b_sum_s = y_ext_s + {{2{s2_kb_cb_r[24]}}, s2_kb_cb_r} + RND_C;

    // Stage 3: round, saturate and pack; this register is the output port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout_valid <= 1'b0;
            dataout       <= 32'd0;
        end else if (en_s) begin
            dataout_valid <= s2_valid_r;
            dataout       <= {sat_u8(b_sum_s), sat_u8(g_sum_s), sat_u8(r_sum_s), 8'h00};
        end
    end

endmodule

// File: tb/tb_ycrcb_to_rgb_converter.sv
// Self-checking bench for ycrcb_to_rgb_converter: directed vector table,
// throughput, random backpressure against a golden model, mid-stream reset.
module tb_ycrcb_to_rgb_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] datain;
    logic        datain_valid;
    logic        datain_ready;
    logic [31:0] dataout;
    logic        dataout_valid;
    logic        dataout_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ycrcb_to_rgb_converter #(.DATAIN_WIDTH(32), .DATAOUT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .datain_ready  (datain_ready),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .dataout_ready (dataout_ready)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] clamp(input int v);
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return 8'(v);
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] d);
        int y, cr, cb, r, g, b;
        y  = int'(d[31:24]);
        cr = int'(d[23:16]) - 128;
        cb = int'(d[15:8]) - 128;
        r  = (y * 16384 + 22970 * cr + 8192) >>> 14;
        g  = (y * 16384 - 5638 * cb - 11700 * cr + 8192) >>> 14;
        b  = (y * 16384 + 29032 * cb + 8192) >>> 14;
        return {clamp(b), clamp(g), clamp(r), 8'h00};
    endfunction

    initial begin
        int          cycles;
        int          sent;
        int          got;
        int          first_c;
        int          last_c;
        int          accepted;
        int          fill;
        logic        prev_stall;
        logic        prev_accept;
        logic [31:0] prev_dout;
        logic [31:0] post_in[2];
        logic [31:0] post_exp[2];

        vecs[0] = '{32'h80808000, 32'h80808000};
        vecs[1] = '{32'hFFFF8000, 32'hFFA4FF00};
        vecs[2] = '{32'h00000000, 32'h00870000};
        vecs[3] = '{32'h808080FF, 32'h80808000};
        vecs[4] = '{32'h80C04000, 32'h0F68DA00};
        vecs[5] = '{32'h1080FF00, 32'hF1001000};
        vecs[6] = '{32'hC820E05A, 32'hFFEC4100};

        // ---------------- reset behaviour ----------------
        rst           = 1'b0;
        datain        = 32'h80808000;
        datain_valid  = 1'b1;
        dataout_ready = 1'b1;
        repeat (3) @(negedge clk);
        check32("rst_dout_valid", {31'd0, dataout_valid}, 32'd0);
        check32("rst_din_ready", {31'd0, datain_ready}, 32'd0);
        check32("rst_dout", dataout, 32'd0);
        rst = 1'b1;
        #1;
        check32("ready_before_edge", {31'd0, datain_ready}, 32'd0);
        @(negedge clk);
        check32("ready_first_edge", {31'd0, datain_ready}, 32'd1);
        datain_valid = 1'b0;
        repeat (5) @(negedge clk);
        check32("no_out_after_rst", {31'd0, dataout_valid}, 32'd0);

        // ---------------- directed vector table with latency ----------------
        for (int i = 0; i < 7; i++) begin
            check32("vec_ready", {31'd0, datain_ready}, 32'd1);
            datain       = vecs[i].din;
            datain_valid = 1'b1;
            cycles       = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                cycles++;
                datain_valid = 1'b0;
                datain       = 32'hDEADBEEF;
                if (dataout_valid) break;
            end
            check32("vec_latency", 32'(cycles), 32'd3);
            check32("vec_data", dataout, vecs[i].dout);
            @(negedge clk);
        end

        // ---------------- 256-pixel throughput ----------------
        exp_q.delete();
        sent    = 0;
        got     = 0;
        first_c = -1;
        last_c  = -1;
        dataout_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dataout_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
                if (exp_q.size() == 0) begin
                    check32("tp_extra_output", 32'd1, 32'd0);
                end else begin
                    check32("tp_data", dataout, exp_q.pop_front());
                end
            end
            if (sent < 256) begin
                check32("tp_ready", {31'd0, datain_ready}, 32'd1);
                datain       = {8'(sent), 8'(sent * 7), 8'(255 - sent), 8'hA5};
                datain_valid = 1'b1;
                exp_q.push_back(golden(datain));
                sent++;
            end else begin
                datain_valid = 1'b0;
            end
        end
        check32("tp_count", 32'(got), 32'd256);
        check32("tp_consecutive", 32'(last_c - first_c), 32'd255);

        // ---------------- random backpressure ----------------
        exp_q.delete();
        accepted    = 0;
        cycles      = 0;
        prev_stall  = 1'b0;
        prev_accept = 1'b0;
        prev_dout   = 32'd0;
        while ((accepted < 10000 || exp_q.size() != 0) && cycles < 80000) begin
            @(negedge clk);
            cycles++;
            if (prev_stall) begin
                check32("bp_hold_valid", {31'd0, dataout_valid}, 32'd1);
                check32("bp_hold_data", dataout, prev_dout);
                if (prev_accept) begin
                    check32("bp_ready_drop", {31'd0, datain_ready}, 32'd0);
                end
            end
            datain        = $urandom;
            datain_valid  = (accepted < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            dataout_ready = (accepted < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            prev_accept = datain_valid && datain_ready;
            if (prev_accept) begin
                exp_q.push_back(golden(datain));
                accepted++;
            end
            if (dataout_valid && dataout_ready) begin
                if (exp_q.size() == 0) begin
                    check32("bp_extra_output", 32'd1, 32'd0);
                end else begin
                    check32("bp_data", dataout, exp_q.pop_front());
                end
            end
            check32("bp_occupancy", {31'd0, exp_q.size() <= 4}, 32'd1);
            prev_stall = dataout_valid && !dataout_ready;
            prev_dout  = dataout;
        end
        check32("bp_accepted", 32'(accepted), 32'd10000);
        check32("bp_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- mid-stream asynchronous reset ----------------
        @(negedge clk);
        datain_valid  = 1'b0;
        dataout_ready = 1'b0;
        fill          = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!datain_ready) break;
            datain       = {8'(k * 16 + 5), 8'(k * 3), 8'(200 - k), 8'h00};
            datain_valid = 1'b1;
            fill++;
        end
        check32("mr_fill", 32'(fill), 32'd4);
        check32("mr_stalled_valid", {31'd0, dataout_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check32("mr_async_valid", {31'd0, dataout_valid}, 32'd0);
        check32("mr_async_ready", {31'd0, datain_ready}, 32'd0);
        check32("mr_async_dout", dataout, 32'd0);
        datain_valid  = 1'b0;
        dataout_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        post_in[0]  = 32'h80808000;
        post_exp[0] = 32'h80808000;
        post_in[1]  = 32'h00000000;
        post_exp[1] = 32'h00870000;
        got = 0;
        for (int c = 0; c < 15; c++) begin
            if (c < 2) begin
                datain       = post_in[c];
                datain_valid = 1'b1;
            end else begin
                datain_valid = 1'b0;
            end
            @(negedge clk);
            if (dataout_valid) begin
                if (got < 2) begin
                    check32("mr_post_data", dataout, post_exp[got]);
                end else begin
                    check32("mr_extra_output", dataout, 32'hFFFFFFFF);
                end
                got++;
            end
        end
        check32("mr_post_count", 32'(got), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
